// File: rtl/spi_slave.sv
// SPI slave, one bit per clk: a select bit then a 10-bit command word forwarded to RAM;
// a read-data command returns one RAM byte on MISO.
module spi_slave #(
  parameter int TX_WAIT_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic [2:0] state_dbg,
  output logic       rd_flag_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  // Progress within a WRITE/READ_ADD/READ_DATA frame.
  typedef enum logic [1:0] {
    PH_SHIFT = 2'd0,
    PH_WAIT  = 2'd1,
    PH_SEND  = 2'd2,
    PH_HOLD  = 2'd3
  } phase_t;

  localparam int WCW = (TX_WAIT_MAX > 1) ? $clog2(TX_WAIT_MAX) : 1;

  state_t         state;
  phase_t         phase;
  logic [3:0]     bit_cnt;
  logic [WCW-1:0] wait_cnt;
  logic [3:0]     send_cnt;
  logic [8:0]     shreg;
  logic [7:0]     tx_byte;
  logic           rd_flag;

  assign state_dbg   = state;
  assign rd_flag_dbg = rd_flag;

  // rx_valid and tx_valid are single-cycle strobes with no back-pressure: rx_valid
  // qualifies rx_data for exactly one cycle, and tx_valid is honoured only during
  // the TX_WAIT_MAX-cycle wait window that opens with the READ_DATA rx_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= PH_SHIFT;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      send_cnt <= '0;
      shreg    <= '0;
      tx_byte  <= '0;
      rd_flag  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      MISO     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (!SS_n) state <= CHK_CMD;
        end
        CHK_CMD: begin
          bit_cnt <= '0;
          phase   <= PH_SHIFT;
          if (SS_n)         state <= IDLE;
          else if (!MOSI)   state <= WRITE;
          else if (rd_flag) state <= READ_DATA;
          else              state <= READ_ADD;
        end
        default: begin
          if (SS_n) begin
            state    <= IDLE;
            phase    <= PH_SHIFT;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            send_cnt <= '0;
            MISO     <= 1'b0;
          end else begin
            case (phase)
              PH_SHIFT: begin
                shreg <= {shreg[7:0], MOSI};
                if (bit_cnt == 4'd9) begin
                  rx_data  <= {shreg, MOSI};
                  rx_valid <= 1'b1;
                  bit_cnt  <= '0;
                  wait_cnt <= '0;
                  if (state == READ_ADD) rd_flag <= 1'b1;
                  phase <= (state == READ_DATA) ? PH_WAIT : PH_HOLD;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
              PH_WAIT: begin
                if (tx_valid) begin
                  tx_byte  <= tx_data;
                  MISO     <= tx_data[7];
                  send_cnt <= 4'd1;
                  phase    <= PH_SEND;
                end else if (wait_cnt == WCW'(TX_WAIT_MAX - 1)) begin
                  rd_flag <= 1'b0;
                  phase   <= PH_HOLD;
                end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                end
              end
              PH_SEND: begin
                // tx_byte shifts left so bit 6 is always the next bit to drive.
                if (send_cnt == 4'd8) begin
                  MISO     <= 1'b0;
                  rd_flag  <= 1'b0;
                  send_cnt <= '0;
                  phase    <= PH_HOLD;
                end else begin
                  MISO     <= tx_byte[6];
                  tx_byte  <= {tx_byte[6:0], 1'b0};
                  send_cnt <= send_cnt + 4'd1;
                end
              end
              default: MISO <= 1'b0;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of frames plus hand-written read, timeout,
// abort and reset sequences.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst, SS_n, MOSI, tx_valid;
  logic [7:0] tx_data;
  logic       MISO, rx_valid, rd_flag_dbg;
  logic [9:0] rx_data;
  logic [2:0] state_dbg;

  localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_WRITE = 3'd2,
                         S_RADD = 3'd3, S_RDATA = 3'd4;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_q[$];
  logic [9:0] last_rx = '0;

  typedef struct {
    logic       sel;
    logic [9:0] word;
    int         nbits;
    logic [2:0] exp_state;
    logic       exp_rd;
  } frame_vec_t;

  frame_vec_t vecs[6];

  spi_slave #(.TX_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .state_dbg(state_dbg), .rd_flag_dbg(rd_flag_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic m, input logic tv,
                      input logic [7:0] td);
    logic [9:0] e;
    rst = r; SS_n = s; MOSI = m; tx_valid = tv; tx_data = td;
    @(posedge clk);
    #1;
    if (rx_valid) begin
      if (exp_q.size() == 0) check("unexpected_rx_valid", 32'(rx_data), 32'h400);
      else begin
        e = exp_q.pop_front();
        check("scoreboard_rx_data", 32'(rx_data), 32'(e));
        last_rx = e;
      end
    end
  endtask

  task automatic start_frame(input logic sel, input logic [2:0] exp_state);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("chk_cmd_state", 32'(state_dbg), 32'(S_CHK));
    step(1'b0, 1'b0, sel, 1'b0, 8'h00);
    check("frame_state", 32'(state_dbg), 32'(exp_state));
  endtask

  // Shift n bits of w MSB first; a short frame is aborted with SS_n high on bit n.
  task automatic shift_bits(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, w[9-i], 1'b0, 8'h00);
      check("miso_zero_shift", 32'(MISO), 0);
      if (i < 9) check("no_early_rx_valid", 32'(rx_valid), 0);
    end
    if (n == 10) begin
      check("rx_valid_strobe", 32'(rx_valid), 1);
      check("rx_data_word", 32'(rx_data), 32'(w));
    end else begin
      step(1'b0, 1'b1, w[9-n], 1'b0, 8'h00);
      check("abort_idle", 32'(state_dbg), 32'(S_IDLE));
      check("abort_no_rx_valid", 32'(rx_valid), 0);
    end
  endtask

  task automatic end_frame();
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("end_idle", 32'(state_dbg), 32'(S_IDLE));
    check("end_miso", 32'(MISO), 0);
  endtask

  task automatic run_frame(input logic sel, input logic [9:0] w, input int n,
                           input logic [2:0] exp_state);
    start_frame(sel, exp_state);
    if (n == 10) exp_q.push_back(w);
    shift_bits(w, n);
    if (n == 10) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        check("hold_no_rx_valid", 32'(rx_valid), 0);
        check("hold_miso", 32'(MISO), 0);
      end
      end_frame();
    end
    check("rx_data_held", 32'(rx_data), 32'(last_rx));
  endtask

  initial begin
    logic [7:0] byte_a5;
    byte_a5 = 8'hA5;

    vecs[0] = '{1'b0, 10'h010, 10, S_WRITE, 1'b0};
    vecs[1] = '{1'b0, 10'h1A5, 10, S_WRITE, 1'b0};
    vecs[2] = '{1'b0, 10'h3FF, 5,  S_WRITE, 1'b0};
    vecs[3] = '{1'b0, 10'h2C3, 10, S_WRITE, 1'b0};
    vecs[4] = '{1'b0, 10'h155, 9,  S_WRITE, 1'b0};
    vecs[5] = '{1'b1, 10'h210, 10, S_RADD,  1'b1};

    // Reset, including reset winning over active SS_n / tx_valid.
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_miso", 32'(MISO), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_rd_flag", 32'(rd_flag_dbg), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      run_frame(vecs[i].sel, vecs[i].word, vecs[i].nbits, vecs[i].exp_state);
      check("vec_rd_flag", 32'(rd_flag_dbg), 32'(vecs[i].exp_rd));
    end

    // Read data: 0x300 in READ_DATA, tx byte 0xA5 one cycle after rx_valid.
    start_frame(1'b1, S_RDATA);
    exp_q.push_back(10'h300);
    shift_bits(10'h300, 10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rd_wait_miso", 32'(MISO), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
      else        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h0F);
      check("rd_miso_bit", 32'(MISO), 32'(byte_a5[7-i]));
      check("rd_flag_during_send", 32'(rd_flag_dbg), 1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rd_done_miso", 32'(MISO), 0);
    check("rd_done_flag", 32'(rd_flag_dbg), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    check("rd_late_tx_ignored", 32'(MISO), 0);
    end_frame();

    // Timeout: READ_ADD then READ_DATA with no tx_valid in the window.
    run_frame(1'b1, 10'h2AB, 10, S_RADD);
    check("to_rd_flag_set", 32'(rd_flag_dbg), 1);
    start_frame(1'b1, S_RDATA);
    exp_q.push_back(10'h3AB);
    shift_bits(10'h3AB, 10);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      check("to_rd_flag", 32'(rd_flag_dbg), (i < 4) ? 1 : 0);
      check("to_miso", 32'(MISO), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
      check("to_tx_ignored_miso", 32'(MISO), 0);
    end
    end_frame();
    run_frame(1'b1, 10'h2CD, 10, S_RADD);
    check("to_readd_rd_flag", 32'(rd_flag_dbg), 1);

    // Reset after 3 MISO bits of 0xC3.
    start_frame(1'b1, S_RDATA);
    exp_q.push_back(10'h355);
    shift_bits(10'h355, 10);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hC3);
    check("rst_seq_bit7", 32'(MISO), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_seq_bit6", 32'(MISO), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_seq_bit5", 32'(MISO), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    last_rx = '0;
    check("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("mid_rst_miso", 32'(MISO), 0);
    check("mid_rst_rd_flag", 32'(rd_flag_dbg), 0);
    check("mid_rst_rx_valid", 32'(rx_valid), 0);
    check("mid_rst_rx_data", 32'(rx_data), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    run_frame(1'b0, 10'h0F0, 10, S_WRITE);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter TX_WAIT_MAX, default 4: max clk cycles READ_DATA waits for tx_valid before abandoning the read.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on posedge; SPI bit rate = one bit per clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port SS_n, input, 1: slave select, active-low; frames a transaction.
REQ-005 SHALL have port MOSI, input, 1: serial data in, MSB first.
REQ-006 SHALL have port MISO, output, 1: serial data out, MSB first; 0 when not shifting.
REQ-007 SHALL have port rx_data, output, 10: received word to RAM; {op[1:0], payload[7:0]}.
REQ-008 SHALL have port rx_valid, output, 1: one-cycle strobe, rx_data valid.
REQ-009 SHALL have port tx_data, input, 8: RAM read data.
REQ-010 SHALL have port tx_valid, input, 1: one-cycle strobe, tx_data valid.

Function
REQ-011 SHALL implement FSM states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, all registered.
REQ-012 IDLE: SS_n=0 sampled -> CHK_CMD next cycle; else stay.
REQ-013 CHK_CMD: sample MOSI as select bit (not part of rx_data); 0 -> WRITE; 1 with rd_flag=0 -> READ_ADD; 1 with rd_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL shift exactly 10 MOSI bits, one per clk, MSB first, via 4-bit counter 0..9.
REQ-015 After 10th bit: rx_data SHALL update to the shifted word and rx_valid SHALL be high exactly one cycle; no further rx_valid in that frame.
REQ-016 rx_data SHALL hold its value between strobes.
REQ-017 WRITE/READ_ADD after strobe: ignore MOSI, stay until SS_n=1.
REQ-018 rd_flag SHALL set on READ_ADD strobe; clear on READ_DATA completion or timeout.
REQ-019 READ_DATA after strobe: wait for tx_valid; on tx_valid latch tx_data; next 8 cycles drive MISO = latched bits 7..0, one per clk.
REQ-020 No tx_valid within TX_WAIT_MAX cycles of rx_valid: clear rd_flag, MISO stays 0, wait for SS_n=1.
REQ-021 tx_valid outside the READ_DATA wait window SHALL be ignored.
REQ-022 After 8th MISO bit: MISO=0, rd_flag cleared, stay until SS_n=1.
REQ-023 SS_n=1 sampled in any non-IDLE state -> IDLE next cycle; counters clear, MISO=0, no rx_valid; rd_flag unchanged unless REQ-020/REQ-022 already applied.
REQ-024 SS_n=1 in the same cycle as the 10th bit SHALL abort: no rx_valid.
REQ-025 Back-to-back frames SHALL work with one SS_n-high cycle between them.

Reset
REQ-026 rst=1 at a clk edge SHALL force IDLE, rx_data=0, rx_valid=0, MISO=0, rd_flag=0, all counters 0, latched tx byte 0, regardless of state.
REQ-027 rst SHALL take priority over SS_n, MOSI, tx_valid; reset mid-frame drops the frame with no rx_valid.

Verification
REQ-028 Write addr: SS_n low, select 0, bits 00_0001_0000 -> rx_data=0x010, rx_valid one cycle; MISO=0 throughout.
REQ-029 Write data: select 0, bits 01_1010_0101 -> rx_data=0x1A5, single rx_valid pulse.
REQ-030 Read: select 1 with bits 10_0001_0000 -> rx_data=0x210, rd_flag=1; next frame select 1 with bits 11_0000_0000 -> rx_data=0x300; tx_valid with tx_data=0xA5 one cycle later -> MISO 1,0,1,0,0,1,0,1 on next 8 cycles, then rd_flag=0.
REQ-031 Abort: SS_n high after 5 bits of a write -> IDLE next cycle, no rx_valid; following full frame received correctly.
REQ-032 Timeout: READ_DATA frame, tx_valid never asserted -> after 4 cycles rd_flag=0, MISO stays 0; next select 1 enters READ_ADD.
REQ-033 Reset mid-READ_DATA shift after 3 MISO bits -> next cycle IDLE, MISO=0, rd_flag=0, rx_valid=0.
